// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access unit: funct3 codes, load marker, FSM states
// and the access-size decode used by the lane logic.
package mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

    // Undefined funct3 encodings fall back to a full-word access.
    function automatic acc_size_t acc_size(input logic [2:0] funct3, input logic is_store);
        acc_size_t sz;
        if (is_store) begin
            case (funct3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                F3_LW:         sz = SZ_WORD;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus; the access unit is the master, the memory the slave.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );

endinterface

// File: rtl/mem_load_ext.sv
// Load lane select and sign/zero extension of a bus read word.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'b0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'b0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: one bus transaction per load/store, stalling the pipeline
// until ack or timeout. Define MISALIGN_TRAP_EN to abort misaligned accesses with an error.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    mem_access_unit_if.master     bus,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MemErrM
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t      state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;

    logic            pending;
    acc_size_t       size;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;
    logic            misaligned;
    logic [31:0]     load_data;

    always_comb begin
        pending = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
        size    = acc_size(funct3M, MemWriteM);
        case (size)
            SZ_BYTE: begin
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            SZ_HALF: begin
                be_d    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        misaligned = ((size == SZ_HALF) && ALUResultM[0]) ||
                     ((size == SZ_WORD) && (ALUResultM[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    assign StallM = pending & (state_q != DONE) & ~rst;

    mem_load_ext u_load_ext (
        .funct3_i  (f3_q),
        .addr_lo_i (lane_q),
        .rdata_i   (bus.mem_rdata_i),
        .data_o    (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            f3_q            <= 3'b000;
            lane_q          <= 2'b00;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_be_o    <= 4'b0000;
            bus.mem_wdata_o <= '0;
            ReadDataM       <= '0;
            MemErrM         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        bus.mem_addr_o  <= {ALUResultM[31:2], 2'b00};
                        bus.mem_be_o    <= be_d;
                        bus.mem_wdata_o <= wdata_d;
                        bus.mem_we_o    <= MemWriteM;
                        f3_q            <= funct3M;
                        lane_q          <= ALUResultM[1:0];
                        cnt_q           <= '0;
                        if (misaligned) begin
                            // Trapped access never reaches the bus.
                            state_q <= DONE;
                            MemErrM <= 1'b1;
                            if (!MemWriteM) begin
                                ReadDataM <= '0;
                            end
                        end else begin
                            state_q       <= BUSY;
                            bus.mem_req_o <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != CntW'(TIMEOUT_CYCLES)) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (bus.mem_ack_i) begin
                        state_q       <= DONE;
                        bus.mem_req_o <= 1'b0;
                        if (!bus.mem_we_o) begin
                            ReadDataM <= load_data;
                        end
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= DONE;
                        bus.mem_req_o <= 1'b0;
                        MemErrM       <= 1'b1;
                        ReadDataM     <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    MemErrM <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random accesses against a
// behavioural model of lane placement, extension and stall length.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MemErrM;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .bus        (bus),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemErrM    (MemErrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes; undefined encodings are word accesses.
    function automatic int unsigned size_bytes(input logic [2:0] f3, input bit st);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned sz;
        logic [31:0] v;
        sz = size_bytes(f3, 1'b0);
        if (sz == 1) begin
            v = (rd >> (8 * (addr % 4))) & 32'hFF;
            if (f3 == 3'd0 && v > 127) v = v - 256;
        end else if (sz == 2) begin
            v = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v > 32767) v = v - 65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Issue one access in the current cycle and follow it to its DONE cycle.
    // ack_at: cycle offset of the ack (1..TIMEOUT), 0 for no ack at all.
    task automatic run_access(input bit st, input bit ld, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at);
        int unsigned sz;
        bit          trap;
        int          exp_stall;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          stall_cnt;
        bit          done;

        sz   = size_bytes(f3, st);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (addr % sz) != 0;
`endif
        exp_be = (sz == 1) ? 4'(1 << (addr % 4)) :
                 (sz == 2) ? 4'(3 << (2 * ((addr / 2) % 2))) : 4'hF;
        exp_wd = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                 (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

        if (trap) begin
            exp_stall = 1;
            exp_err   = 1'b1;
            if (!st) exp_rd = 32'h0;
        end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
            exp_stall = ack_at + 1;
            exp_err   = 1'b0;
            if (!st) exp_rd = load_model(f3, addr, rd);
        end else begin
            exp_stall = TIMEOUT + 1;
            exp_err   = 1'b1;
            exp_rd    = 32'h0;
        end

        MemWriteM  = st;
        ResultSrcM = st ? (ld ? 2'b01 : 2'b10) : 2'b01;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;

        stall_cnt = -1;
        done      = 1'b0;
        for (int c = 0; c < 60; c++) begin
            bus.mem_ack_i   = (ack_at != 0 && c == ack_at) ||
                              (c == exp_stall && $urandom_range(0, 1) == 1);
            bus.mem_rdata_i = (c == ack_at) ? rd : $urandom;
            @(negedge clk);
            if (!StallM) begin
                stall_cnt = c;
                done      = 1'b1;
                break;
            end
            check_eq("err_while_stalled", {31'b0, MemErrM}, 32'h0);
            if (c == 0) begin
                check_eq("req_first_cycle", {31'b0, bus.mem_req_o}, 32'h0);
            end else begin
                check_eq("req_busy", {31'b0, bus.mem_req_o}, 32'h1);
                check_eq("we", {31'b0, bus.mem_we_o}, {31'b0, st});
                check_eq("addr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
                if (st) begin
                    check_eq("be", {28'b0, bus.mem_be_o}, {28'b0, exp_be});
                    check_eq("wdata", bus.mem_wdata_o, exp_wd);
                end
            end
            @(posedge clk);
            #1;
        end

        check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        if (done) begin
            check_eq("req_done", {31'b0, bus.mem_req_o}, 32'h0);
            check_eq("err_done", {31'b0, MemErrM}, {31'b0, exp_err});
            check_eq("rdata_done", ReadDataM, exp_rd);
            @(posedge clk);
            #1;
        end
        bus.mem_ack_i = 1'b0;
    endtask

    // One cycle with no access pending; acks arriving in IDLE must be ignored.
    task automatic idle_cycle();
        MemWriteM       = 1'b0;
        ResultSrcM      = 2'($urandom_range(0, 1)) << 1;
        bus.mem_ack_i   = $urandom_range(0, 1) == 1;
        bus.mem_rdata_i = $urandom;
        @(negedge clk);
        check_eq("idle_stall", {31'b0, StallM}, 32'h0);
        check_eq("idle_req", {31'b0, bus.mem_req_o}, 32'h0);
        check_eq("idle_err", {31'b0, MemErrM}, 32'h0);
        check_eq("idle_rdata", ReadDataM, exp_rd);
        @(posedge clk);
        #1;
        bus.mem_ack_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, {31'b0, bus.mem_req_o}, 32'h0);
        check_eq({tag, "_we"}, {31'b0, bus.mem_we_o}, 32'h0);
        check_eq({tag, "_addr"}, bus.mem_addr_o, 32'h0);
        check_eq({tag, "_be"}, {28'b0, bus.mem_be_o}, 32'h0);
        check_eq({tag, "_wdata"}, bus.mem_wdata_o, 32'h0);
        check_eq({tag, "_rdata"}, ReadDataM, 32'h0);
        check_eq({tag, "_err"}, {31'b0, MemErrM}, 32'h0);
        check_eq({tag, "_stall"}, {31'b0, StallM}, 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        MemWriteM       = 1'b0;
        ResultSrcM      = 2'b01;
        funct3M         = 3'b010;
        ALUResultM      = 32'h0;
        WriteDataM      = 32'h0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;

        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        ResultSrcM = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1);
        run_access(1'b0, 1'b0, 3'd0, 32'h0000_2002, 32'h0, 32'h0080_0000, 1);
        run_access(1'b0, 1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'h0080_0000, 1);
        run_access(1'b0, 1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 5);
        run_access(1'b0, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'h1234_5678, 0);
        idle_cycle();
        run_access(1'b0, 1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'hFEDC_BA98, TIMEOUT);
        run_access(1'b1, 1'b1, 3'd2, 32'h0000_2004, 32'hCAFE_F00D, 32'h5555_5555, 2);
        run_access(1'b0, 1'b0, 3'd2, 32'h0000_3001, 32'h0, 32'hA5A5_0F0F, 1);
        run_access(1'b0, 1'b0, 3'd7, 32'h0000_3000, 32'h0, 32'h0BAD_BEEF, 3);

        // Reset in the middle of a load, then a stray ack.
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        funct3M    = 3'd2;
        ALUResultM = 32'h0000_4000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("req_before_rst", {31'b0, bus.mem_req_o}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        ResultSrcM = 2'b00;
        @(negedge clk);
        rst    = 1'b0;
        exp_rd = 32'h0;
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = $urandom;
            @(negedge clk);
            check_eq("stray_ack_rdata", ReadDataM, 32'h0);
            check_eq("stray_ack_req", {31'b0, bus.mem_req_o}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.mem_ack_i = 1'b0;

        // Random accesses, back-to-back or separated by idle cycles.
        for (int i = 0; i < 80; i++) begin
            bit          st;
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          ack_at;
            st   = $urandom_range(0, 1) == 1;
            ld   = $urandom_range(0, 1) == 1;
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            case ($urandom_range(0, 9))
                0:       ack_at = 0;
                1:       ack_at = TIMEOUT;
                default: ack_at = $urandom_range(1, 8);
            endcase
            run_access(st, ld, f3, addr, $urandom, $urandom, ack_at);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller for the pipelined RV32 core. It consumes the execute/memory pipeline register outputs: address, store data, funct3, MemWrite and ResultSrc. For each load or store it runs a request/acknowledge transaction on the data-memory bus and stalls the pipeline until the transaction completes. It produces the lane-aligned, sign- or zero-extended load data for the memory/writeback register.

## Interface
- DATA_WIDTH, 32: datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 16: number of BUSY cycles without an ack before the access is aborted.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ResultSrcM  in  2  2'b01 marks a load.
- MemWriteM  in  1  marks a store.
- funct3M  in  3  access size and signedness.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  32  word address {ALUResultM[31:2], 2'b00}.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-positioned store data.
- mem_rdata_i  in  32  bus read data.
- mem_ack_i  in  1  bus completion.
- ReadDataM  out  32  extended load result.
- StallM  out  1  holds the IF, ID, EX and MEM pipeline registers.
- MemErrM  out  1  one-cycle error flag.

## Operation
- An access is pending when MemWriteM=1 or ResultSrcM=2'b01.
  - If both are asserted, the access is a store and ReadDataM is unchanged.
- State machine:
  - IDLE to BUSY when an access is pending. On that edge the unit registers addr, be, wdata and we, and sets mem_req_o.
  - BUSY to DONE on mem_ack_i. A load captures the extended mem_rdata_i into ReadDataM. mem_req_o clears.
  - BUSY to DONE after TIMEOUT_CYCLES BUSY cycles with no ack. MemErrM=1, ReadDataM=0, mem_req_o clears.
  - If the ack arrives in the same cycle the timeout expires, the ack wins.
  - DONE to IDLE unconditionally.
- StallM = pending & (state != DONE) & ~rst. This is combinational.
- mem_ack_i is ignored in IDLE and DONE.
- Store lanes:
  - sb: be = 4'b0001 << addr[1:0]; the byte is replicated to all four lanes.
  - sh: be = 4'b0011 << {addr[1], 1'b0}; the half is replicated to both halves.
  - sw: be = 4'b1111.
- Load lanes:
  - lb/lbu select the byte at addr[1:0].
  - lh/lhu select the half at addr[1].
  - lb and lh sign-extend; lbu and lhu zero-extend.
- Any undefined funct3 behaves as lw/sw.
- Reset values: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, ReadDataM=0, MemErrM=0, timeout counter=0, StallM=0.
- Reset mid-transaction abandons the access; any later ack is ignored.

## Timing
- Access seen in IDLE in cycle N:
  - StallM=1 in N.
  - mem_req_o=1 from N+1.
- With an ack in cycle N+k, the unit is in DONE in N+k+1:
  - StallM=0 in that cycle and the pipeline advances at its end.
  - Minimum stall is 2 cycles (ack in N+1).
- ReadDataM is valid in the DONE cycle and holds until the next load capture.
- MemErrM is high only in the DONE cycle.
- mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o stay stable while mem_req_o=1.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Clears on entry to BUSY and saturates.
- Back-to-back accesses: the DONE cycle, then IDLE sees the next instruction in the following cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access (lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0) issues no bus request.
  - IDLE goes directly to DONE with MemErrM=1. A misaligned load returns ReadDataM=0.
- MISALIGN_TRAP_EN undefined:
  - Halfword accesses ignore addr[0].
  - Word accesses ignore addr[1:0].
  - No error is raised.

## Structure
- Package mem_pkg holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - RESULT_SRC_LOAD = 2'b01.
  - typedef enum mem_state_t {IDLE, BUSY, DONE}.
- Sub-module mem_load_ext: combinational lane select and extension (funct3, addr[1:0], rdata to data).

## Test plan
- sb at 0x1003, WriteDataM=0x000000AB, ack in N+1: mem_be_o=4'b1000, mem_wdata_o=0xABABABAB, StallM high for exactly 2 cycles.
- lb at 0x2002, rdata=0x00800000: ReadDataM=0xFFFFFF80. lbu at the same address: ReadDataM=0x00000080.
- lh at 0x2002, rdata=0x8001_0000, ack delayed 5 cycles: StallM high for 6 cycles, ReadDataM=0xFFFF8001.
- Load with no ack, TIMEOUT_CYCLES=16: DONE entered after 16 BUSY cycles, MemErrM pulses for 1 cycle, ReadDataM=0. An ack in the timeout cycle completes normally.
- rst asserted mid-BUSY: outputs immediately return to reset values, and a later ack produces no ReadDataM change.
- With MISALIGN_TRAP_EN, lw at 0x3001: mem_req_o stays 0, MemErrM=1 in the next cycle. Without it: a word read from 0x3000.
